// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared state codes, opcodes and ALU operations for the multi-cycle control unit
package control_pkg;

   typedef enum logic [3:0] {
      ST_FETCH    = 4'd0,
      ST_DECODE   = 4'd1,
      ST_EXEC_R   = 4'd2,
      ST_ALU_WB   = 4'd3,
      ST_MEM_ADDR = 4'd4,
      ST_MEM_RD   = 4'd5,
      ST_MEM_WB   = 4'd6,
      ST_MEM_WR   = 4'd7,
      ST_BRANCH   = 4'd8,
      ST_ADDI_EX  = 4'd9,
      ST_ADDI_WB  = 4'd10
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // States that hold a memory request open and may time out.
   function automatic logic is_wait_state(input state_t s);
      return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
   endfunction

endpackage

// File: rtl/contador_espera.sv
// rtl/contador_espera.sv - memory wait counter; expired flags the last allowed wait cycle
module contador_espera #(
   parameter int WAIT_MAX = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CW-1:0] LAST = (WAIT_MAX > 0) ? CW'(WAIT_MAX - 1) : '0;

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // WAIT_MAX of zero means the unit waits on memory forever.
   assign expired = (WAIT_MAX > 0) && (cnt_q == LAST);

endmodule

// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - Moore multi-cycle control unit with memory wait timeout
module unidad_control_multiciclo
   import control_pkg::*;
#(
   parameter int OP_W     = 6,
   parameter int ALUOP_W  = 3,
   parameter int WAIT_MAX = 16,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [OP_W-1:0]    OPcode,
   input  logic               mem_ready,
   output logic               reg_write,
   output logic [ALUOP_W-1:0] alu_op,
   output logic               mem_read,
   output logic               mem_write,
   output logic               mem_to_reg,
   output logic               ir_write,
   output logic               pc_write,
   output logic               pc_write_cond,
   output logic               alu_src_imm,
   output logic               instr_done,
   output logic               illegal_op,
   output logic               mem_timeout,
   output logic [CNT_W-1:0]   instr_count,
   output logic [3:0]         estado
);

   localparam logic [OP_W-1:0] OPC_R    = OP_W'(OP_RTYPE);
   localparam logic [OP_W-1:0] OPC_LW   = OP_W'(OP_LW);
   localparam logic [OP_W-1:0] OPC_SW   = OP_W'(OP_SW);
   localparam logic [OP_W-1:0] OPC_BEQ  = OP_W'(OP_BEQ);
   localparam logic [OP_W-1:0] OPC_ADDI = OP_W'(OP_ADDI);

   localparam logic [ALUOP_W-1:0] AOP_ADD   = ALUOP_W'(ALU_ADD);
   localparam logic [ALUOP_W-1:0] AOP_SUB   = ALUOP_W'(ALU_SUB);
   localparam logic [ALUOP_W-1:0] AOP_FUNCT = ALUOP_W'(ALU_FUNCT);

   state_t           state_q, state_d;
   logic             store_q, store_d;
   logic             illegal_q, illegal_d;
   logic             timeout_q, timeout_d;
   logic [CNT_W-1:0] count_q;
   logic             waiting, expired, abort, clr_wait;

   assign waiting   = is_wait_state(state_q) && !mem_ready;
   assign abort     = waiting && expired;
   assign timeout_d = abort;
   assign clr_wait  = (state_d != state_q) || abort;

   contador_espera #(
      .WAIT_MAX (WAIT_MAX)
   ) u_espera (
      .clk     (clk),
      .rst     (rst),
      .clr     (clr_wait),
      .en      (waiting),
      .expired (expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         store_q   <= 1'b0;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         store_q   <= store_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
         if (instr_done) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      store_d       = store_q;
      illegal_d     = 1'b0;
      reg_write     = 1'b0;
      alu_op        = AOP_ADD;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      alu_src_imm   = 1'b0;
      instr_done    = 1'b0;

      unique case (state_q)
         ST_FETCH: begin
            mem_read = 1'b1;
            if (abort) begin
               state_d = ST_FETCH;
            end else if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = ST_DECODE;
            end
         end
         ST_DECODE: begin
            // MEM_ADDR needs to know load vs store after OPcode may have moved on.
            store_d = (OPcode == OPC_SW);
            if (OPcode == OPC_R) begin
               state_d = ST_EXEC_R;
            end else if ((OPcode == OPC_LW) || (OPcode == OPC_SW)) begin
               state_d = ST_MEM_ADDR;
            end else if (OPcode == OPC_BEQ) begin
               state_d = ST_BRANCH;
            end else if (OPcode == OPC_ADDI) begin
               state_d = ST_ADDI_EX;
            end else begin
               illegal_d = 1'b1;
               state_d   = ST_FETCH;
            end
         end
         ST_EXEC_R: begin
            alu_op  = AOP_FUNCT;
            state_d = ST_ALU_WB;
         end
         ST_ALU_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            alu_op     = AOP_FUNCT;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_MEM_ADDR: begin
            alu_src_imm = 1'b1;
            state_d     = store_q ? ST_MEM_WR : ST_MEM_RD;
         end
         ST_MEM_RD: begin
            mem_read = 1'b1;
            if (abort) begin
               state_d = ST_FETCH;
            end else if (mem_ready) begin
               state_d = ST_MEM_WB;
            end
         end
         ST_MEM_WB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_MEM_WR: begin
            mem_write = 1'b1;
            if (abort) begin
               state_d = ST_FETCH;
            end else if (mem_ready) begin
               instr_done = 1'b1;
               state_d    = ST_FETCH;
            end
         end
         ST_BRANCH: begin
            pc_write_cond = 1'b1;
            alu_op        = AOP_SUB;
            instr_done    = 1'b1;
            state_d       = ST_FETCH;
         end
         ST_ADDI_EX: begin
            alu_src_imm = 1'b1;
            state_d     = ST_ADDI_WB;
         end
         ST_ADDI_WB: begin
            reg_write   = 1'b1;
            mem_to_reg  = 1'b1;
            alu_src_imm = 1'b1;
            instr_done  = 1'b1;
            state_d     = ST_FETCH;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   assign illegal_op  = illegal_q;
   assign mem_timeout = timeout_q;
   assign instr_count = count_q;
   assign estado      = state_q;

endmodule

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

Parametrised multi-cycle control unit: successor to the single-cycle R-type decoder. A Moore FSM sequences each instruction through fetch, decode, execute, memory and write-back. It supports R-type, LW, SW, BEQ and ADDI, and waits on a ready/valid memory handshake with a configurable timeout. It sits between the instruction register/memory interface and the datapath, and drives all datapath enables plus an instruction-retired counter.

## Interface
- `OP_W`, 6, opcode width.
- `ALUOP_W`, 3, ALU-operation field width (≥2).
- `WAIT_MAX`, 16, max memory wait cycles before abort; 0 disables timeout.
- `CNT_W`, 32, retired-instruction counter width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `OPcode` in OP_W: opcode from instruction register; sampled in DECODE.
- `mem_ready` in 1: memory completes the current read/write this cycle.
- `reg_write` out 1: register file write enable.
- `alu_op` out ALUOP_W: 000 add, 001 sub, 010 R-type (funct decode).
- `mem_read` out 1; `mem_write` out 1: memory request, held until `mem_ready`.
- `mem_to_reg` out 1: 1 = ALU result, 0 = memory data.
- `ir_write` out 1; `pc_write` out 1; `pc_write_cond` out 1 (datapath ANDs with zero).
- `alu_src_imm` out 1: ALU operand B = sign-extended immediate.
- `instr_done` out 1: final cycle of a retiring instruction.
- `illegal_op` out 1; `mem_timeout` out 1: one-cycle pulses.
- `instr_count` out CNT_W: retired instructions, wraps.
- `estado` out 4: current state code, for debug.

## Operation
- Opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, ADDI 001000; all others illegal.
- States and codes: FETCH 0, DECODE 1, EXEC_R 2, ALU_WB 3, MEM_ADDR 4, MEM_RD 5, MEM_WB 6, MEM_WR 7, BRANCH 8, ADDI_EX 9, ADDI_WB 10.
- FETCH: `mem_read`=1, `alu_op`=000.
  - While `mem_ready`=1: `ir_write`=1 and `pc_write`=1; next state DECODE. Otherwise stay.
- DECODE: branch on OPcode.
  - R → EXEC_R; LW/SW → MEM_ADDR; BEQ → BRANCH; ADDI → ADDI_EX.
  - Illegal → FETCH with `illegal_op` pulse; not counted as retired.
- EXEC_R: `alu_op`=010 → ALU_WB.
- ALU_WB: `reg_write`=1, `mem_to_reg`=1, `alu_op`=010 → FETCH.
- MEM_ADDR: `alu_src_imm`=1, `alu_op`=000 → MEM_RD (LW) or MEM_WR (SW).
- MEM_RD: `mem_read`=1; on `mem_ready` → MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=0 → FETCH.
- MEM_WR: `mem_write`=1; on `mem_ready` → FETCH.
- BRANCH: `pc_write_cond`=1, `alu_op`=001 → FETCH.
- ADDI_EX: `alu_src_imm`=1, `alu_op`=000 → ADDI_WB.
- ADDI_WB: `reg_write`=1, `mem_to_reg`=1, `alu_src_imm`=1 → FETCH.
- Unlisted outputs are 0 in every state.
- `instr_done`=1 in ALU_WB, MEM_WB, BRANCH, ADDI_WB, and in MEM_WR while `mem_ready`=1. `instr_count` increments on that same edge, modulo 2^CNT_W.
- Timeout:
  - `wait_cnt` clears on every state change.
  - In FETCH, MEM_RD or MEM_WR with `mem_ready`=0, it increments.
  - If `wait_cnt`==WAIT_MAX−1 and `mem_ready`=0 (WAIT_MAX>0), next state is FETCH and `mem_timeout` pulses the following cycle.
  - The aborted instruction performs no write and is not counted.
- `mem_ready` outside FETCH, MEM_RD or MEM_WR is ignored.

## Timing
- Outputs are combinational from `estado`, plus `mem_ready` for `ir_write`, `pc_write` and `instr_done`. `illegal_op` and `mem_timeout` are registered.
- Cycles with zero memory wait: R 4, LW 5, SW 4, BEQ 3, ADDI 4. Each memory wait cycle adds one.
- Reset: `estado`=FETCH, `wait_cnt`=0, `instr_count`=0, `illegal_op`=`mem_timeout`=0.
  - In the first cycle after reset, outputs are FETCH values: `mem_read`=1, all others 0.
- `rst` mid-instruction abandons it at the next edge; no further write enables are asserted.
- `rst` has priority over `mem_ready`, timeout and counter increment in the same cycle.
- `mem_ready` arriving on the timeout cycle counts as completion; no timeout.

## Structure
- Shared package `control_pkg`: state enum (4-bit codes above), opcode constants, ALU-op constants.
- One sub-module, `contador_espera`: parametrised wait counter with `clr`, `en` and `expired`, WAIT_MAX=0 ⇒ never expires.

## Test plan
- Reset, then R-type (000000), `mem_ready` tied 1: `estado` 0,1,2,3,0. `reg_write` high only in state 3. `instr_count`=1 after 4 cycles.
- LW with `mem_ready` low for 3 cycles in MEM_RD: 8 cycles total. `mem_read` held in MEM_RD for 4 cycles, `mem_to_reg`=0 in MEM_WB. Then SW: `mem_write` for 1 cycle, `instr_done` on the `mem_ready` cycle.
- BEQ, then ADDI back-to-back: `pc_write_cond`=1 with `alu_op`=001 for exactly 1 cycle. ADDI shows `alu_src_imm`=1 in states 9 and 10. Count +2.
- Opcode 111111 in DECODE: `illegal_op` pulse 1 cycle, return to FETCH, `instr_count` unchanged.
- WAIT_MAX=4, `mem_ready`=0 in MEM_RD: after 4 cycles `estado`=FETCH, `mem_timeout` pulse, no `reg_write`. Repeat with WAIT_MAX=0: waits indefinitely (check 100 cycles).
- `rst` asserted in MEM_WB, plus `instr_count` wrap with CNT_W=2: no `reg_write` after reset, count 0. The fourth retirement wraps 3→0.
